gnn_0_example_save: RTL and testbench

Output-save engine of the GNN kernel: on a save instruction it reads a run of wide (16×C_M_AXI_DATA_WIDTH) words from an on-chip result buffer and unpacks each into 16 AXI-width beats. It streams the beats to the AXI write-master stage and reports the DRAM destination and transfer size. It is the write-back counterpart of the weight loader, which packs 16 DRAM beats into one buffer word, and sits between the ctrl module, the output buffer and the AXI write master.

---
 rtl/gnn_0_example_save.sv | 207 ++++++++++++++++++++
 tb/tb_gnn_0_example_save.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_0_example_save.sv
// Output-save engine: reads wide words from the result buffer and unpacks each into
// 16 AXI-width beats for the write master, reporting the DRAM destination and size.
//
// state  | meaning
// IDLE   | waiting for ap_start
// DECODE | empty run finishes here; otherwise start the writer and read the first word
// FILL   | first word lands in the shift register, prefetch of the second word issued
// STREAM | beats go out lowest slice first; the prefetched word swaps in after beat 15
// FLUSH  | all beats sent, waiting for the write master to report completion
module gnn_0_example_save #(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int BUF_ADDR_WIDTH     = 13
) (
  input  logic                             kernel_clk,
  input  logic                             kernel_rst,
  input  logic                             ap_start,
  output logic                             ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]    ctrl_addr_offset,
  input  logic [SAVE_INST_LENGTH-1:0]      ctrl_instruction,
  output logic                             save_read_buffer_r_en,
  output logic [BUF_ADDR_WIDTH-1:0]        save_read_buffer_r_addr,
  input  logic [16*C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_r_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]    dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]     dram_xfer_size_in_bytes,
  output logic                             write_start,
  input  logic                             write_done,
  output logic                             data_tvalid,
  input  logic                             data_tready,
  output logic                             data_tlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0]    data_tdata
);

  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int XW  = C_XFER_SIZE_WIDTH;
  localparam int BAW = BUF_ADDR_WIDTH;
  localparam int WW  = 16 * DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FILL,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t state, state_n;

  logic [WW-1:0]  shift_q;
  logic [WW-1:0]  pref_q;
  logic           pref_valid;
  logic           pref_pend;
  logic [BAW-1:0] buf_start_q;
  logic [BAW-1:0] buf_len_q;
  logic [BAW-1:0] out_word;
  logic [BAW:0]   rd_cnt;
  logic [3:0]     beat_cnt;
  logic           wd_seen;
  logic           ap_done_q;
  logic [AW-1:0]  xfer_addr_q;
  logic [XW-1:0]  xfer_size_q;

  logic           accept;
  logic           set_done;
  logic           rd_en_c;
  logic           words_left;
  logic           stream_hs;
  logic [BAW-1:0] rd_addr;
  logic           unused_inst;

  assign words_left = rd_cnt < {1'b0, buf_len_q};
  assign stream_hs  = (state == S_STREAM) && data_tready;
  assign rd_addr    = buf_start_q + rd_cnt[BAW-1:0];

  assign ap_done                 = ap_done_q;
  assign save_read_buffer_r_en   = rd_en_c;
  assign save_read_buffer_r_addr = rd_en_c ? rd_addr : '0;
  assign data_tdata              = data_tvalid ? shift_q[DW-1:0] : '0;
  assign dram_xfer_start_addr    = xfer_addr_q;
  assign dram_xfer_size_in_bytes = xfer_size_q;

  // Low instruction bits and the truncated tops of the buffer fields carry nothing here.
  assign unused_inst = ^{ctrl_instruction[31:0],
                         ctrl_instruction[47:32+BAW],
                         ctrl_instruction[63:48+BAW]};

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    set_done    = 1'b0;
    rd_en_c     = 1'b0;
    write_start = 1'b0;
    data_tvalid = 1'b0;
    data_tlast  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          accept  = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        if (buf_len_q == '0) begin
          set_done = 1'b1;
          state_n  = S_IDLE;
        end else begin
          write_start = 1'b1;
          rd_en_c     = 1'b1;
          state_n     = S_FILL;
        end
      end
      S_FILL: begin
        rd_en_c = words_left;
        state_n = S_STREAM;
      end
      S_STREAM: begin
        data_tvalid = 1'b1;
        data_tlast  = (beat_cnt == 4'd15) && (out_word == buf_len_q - 1'b1);
        if (data_tready && beat_cnt == 4'd15) begin
          if (pref_valid) begin
            rd_en_c = words_left;
          end else if (wd_seen || write_done) begin
            set_done = 1'b1;
            state_n  = S_IDLE;
          end else begin
            state_n = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (wd_seen || write_done) begin
          set_done = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      shift_q     <= '0;
      pref_q      <= '0;
      pref_valid  <= 1'b0;
      pref_pend   <= 1'b0;
      buf_start_q <= '0;
      buf_len_q   <= '0;
      out_word    <= '0;
      rd_cnt      <= '0;
      beat_cnt    <= '0;
      wd_seen     <= 1'b0;
      ap_done_q   <= 1'b0;
      xfer_addr_q <= '0;
      xfer_size_q <= '0;
    end else begin
      ap_done_q <= set_done;
      if (accept) begin
        buf_start_q <= ctrl_instruction[32 +: BAW];
        buf_len_q   <= ctrl_instruction[48 +: BAW];
        xfer_addr_q <= ctrl_addr_offset + {{(AW-16){1'b0}}, ctrl_instruction[79:64]};
        xfer_size_q <= {{(XW-16){1'b0}}, ctrl_instruction[95:80]};
        wd_seen     <= 1'b0;
        rd_cnt      <= '0;
        out_word    <= '0;
        beat_cnt    <= '0;
        pref_valid  <= 1'b0;
      end else if (write_done && state != S_IDLE && state != S_DECODE) begin
        wd_seen <= 1'b1;
      end

      if (rd_en_c) rd_cnt <= rd_cnt + 1'b1;
      // Reads issued after the first one always land in the prefetch register.
      pref_pend <= rd_en_c && (state == S_FILL || state == S_STREAM);

      if (state == S_FILL) begin
        shift_q  <= save_read_buffer_r_data;
        beat_cnt <= '0;
      end
      if (pref_pend) begin
        pref_q     <= save_read_buffer_r_data;
        pref_valid <= 1'b1;
      end
      if (stream_hs) begin
        if (beat_cnt == 4'd15) begin
          beat_cnt <= '0;
          if (pref_valid) begin
            shift_q    <= pref_q;
            pref_valid <= 1'b0;
            out_word   <= out_word + 1'b1;
          end
        end else begin
          shift_q  <= shift_q >> DW;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gnn_0_example_save.sv
// Scoreboard bench for gnn_0_example_save: expected beats and read addresses are
// queued from a word-level model of the buffer; a negedge monitor pops and compares.
module tb_gnn_0_example_save;
  localparam int DW  = 512;
  localparam int AW  = 64;
  localparam int XW  = 32;
  localparam int BAW = 13;
  localparam int IW  = 96;

  logic                 kernel_clk = 1'b0;
  logic                 kernel_rst = 1'b1;
  logic                 ap_start = 1'b0;
  logic                 ap_done;
  logic [AW-1:0]        ctrl_addr_offset = '0;
  logic [IW-1:0]        ctrl_instruction = '0;
  logic                 save_read_buffer_r_en;
  logic [BAW-1:0]       save_read_buffer_r_addr;
  logic [16*DW-1:0]     save_read_buffer_r_data = '0;
  logic [AW-1:0]        dram_xfer_start_addr;
  logic [XW-1:0]        dram_xfer_size_in_bytes;
  logic                 write_start;
  logic                 write_done = 1'b0;
  logic                 data_tvalid;
  logic                 data_tready = 1'b1;
  logic                 data_tlast;
  logic [DW-1:0]        data_tdata;

  gnn_0_example_save dut (
    .kernel_clk(kernel_clk), .kernel_rst(kernel_rst),
    .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .save_read_buffer_r_en(save_read_buffer_r_en),
    .save_read_buffer_r_addr(save_read_buffer_r_addr),
    .save_read_buffer_r_data(save_read_buffer_r_data),
    .dram_xfer_start_addr(dram_xfer_start_addr),
    .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
    .write_start(write_start), .write_done(write_done),
    .data_tvalid(data_tvalid), .data_tready(data_tready),
    .data_tlast(data_tlast), .data_tdata(data_tdata)
  );

  always #5 kernel_clk = ~kernel_clk;

  int cyc = 0;
  always @(posedge kernel_clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [DW:0]    exp_beats[$];
  logic [BAW-1:0] exp_addr[$];
  logic [BAW-1:0] tb_base = '0;
  logic [31:0]    tb_seed = '0;
  int rmode = 0;

  int hs_cnt, ws_cnt, ren_cnt, done_cnt, ws_cyc, wd_cyc, done_cyc, last_cyc, first_tv_cyc;
  bit last_seen;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Slice k of the buffer word at address a: word index (relative to tb_base) * 0x100 + k.
  function automatic logic [DW-1:0] slice(input logic [BAW-1:0] a, input int k);
    logic [BAW-1:0] w;
    logic [31:0] v;
    w = a - tb_base;
    v = {19'b0, w} * 32'd256 + k;
    return {tb_seed, {416{1'b0}}, tb_seed, v};
  endfunction

  function automatic logic [16*DW-1:0] mkword(input logic [BAW-1:0] a);
    logic [16*DW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*DW +: DW] = slice(a, k);
    return r;
  endfunction

  always @(posedge kernel_clk)
    if (save_read_buffer_r_en) save_read_buffer_r_data <= mkword(save_read_buffer_r_addr);

  initial forever begin
    @(posedge kernel_clk); #1;
    case (rmode)
      0: data_tready = 1'b1;
      1: data_tready = ~data_tready;
      default: data_tready = 1'($urandom_range(0, 1));
    endcase
  end

  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;
  logic [DW:0]   e;
  initial forever begin
    @(negedge kernel_clk);
    if (!kernel_rst) begin
      if (write_start) begin ws_cnt++; ws_cyc = cyc; end
      if (write_done) wd_cyc = cyc;
      if (ap_done) begin done_cnt++; done_cyc = cyc; end
      if (save_read_buffer_r_en) begin
        ren_cnt++;
        if (exp_addr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_read: got addr %0h expected no read", save_read_buffer_r_addr);
        end else chk("r_addr", save_read_buffer_r_addr, exp_addr.pop_front());
      end
      if (data_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (stall_prev) begin
        chk("stall_tvalid", data_tvalid, 1);
        chk("stall_tdata", data_tdata, data_prev);
      end
      if (data_tvalid && data_tready) begin
        hs_cnt++;
        if (exp_beats.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: got %0h expected no beat", data_tdata);
        end else begin
          e = exp_beats.pop_front();
          chk("tdata", data_tdata, e[DW-1:0]);
          chk("tlast", data_tlast, e[DW]);
        end
        if (data_tlast) begin last_seen = 1; last_cyc = cyc; end
      end
      stall_prev = data_tvalid && !data_tready;
      data_prev  = data_tdata;
    end else stall_prev = 1'b0;
  end

  function automatic logic [IW-1:0] mkinst(input logic [15:0] bs, input logic [15:0] bl,
                                           input logic [15:0] ds, input logic [15:0] db);
    return {db, ds, bl, bs, $urandom()};
  endfunction

  task automatic clear_stats();
    hs_cnt = 0; ws_cnt = 0; ren_cnt = 0; done_cnt = 0;
    ws_cyc = -1; wd_cyc = -1; done_cyc = -1; last_cyc = -1; first_tv_cyc = -1;
    last_seen = 0;
  endtask

  task automatic push_model(input logic [15:0] bs_f, input logic [15:0] bl_f);
    int len;
    logic [BAW-1:0] a;
    len = int'(bl_f[BAW-1:0]);
    tb_base = bs_f[BAW-1:0];
    for (int w = 0; w < len; w++) begin
      a = bs_f[BAW-1:0] + BAW'(w);
      exp_addr.push_back(a);
      for (int k = 0; k < 16; k++)
        exp_beats.push_back({(w == len - 1) && (k == 15), slice(a, k)});
    end
  endtask

  task automatic run(input logic [15:0] bs_f, input logic [15:0] bl_f, input logic [15:0] ds,
                     input logic [15:0] db, input logic [AW-1:0] off, input int rm,
                     input int wdmode, input bit mid_start);
    int len, start_cyc;
    bit wd_given, mid_done;
    len = int'(bl_f[BAW-1:0]);
    wd_given = 0; mid_done = 0;
    clear_stats();
    push_model(bs_f, bl_f);
    @(posedge kernel_clk); #1;
    rmode = rm;
    ctrl_instruction = mkinst(bs_f, bl_f, ds, db);
    ctrl_addr_offset = off;
    ap_start = 1'b1;
    start_cyc = cyc;
    for (int b = 0; b < 3000 && done_cnt == 0; b++) begin
      @(posedge kernel_clk); #1;
      ap_start = 1'b0;
      write_done = 1'b0;
      if (wdmode == 0 && ws_cnt > 0 && !wd_given && cyc >= ws_cyc + 4) begin
        write_done = 1'b1; wd_given = 1;
      end
      if (wdmode == 1 && last_seen && !wd_given && cyc == last_cyc + 5) begin
        write_done = 1'b1; wd_given = 1;
      end
      if (mid_start && !mid_done && hs_cnt >= 10) begin
        ap_start = 1'b1;
        ctrl_instruction = mkinst(16'h0005, 16'd3, 16'h1234, 16'h0040);
        ctrl_addr_offset = '1;
        mid_done = 1;
      end
    end
    ap_start = 1'b0;
    write_done = 1'b0;
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ap_done_timeout: got no ap_done expected one within 3000 cycles");
    end
    repeat (3) @(posedge kernel_clk);
    #1;
    rmode = 0;
    chk("ap_done_count", done_cnt, 1);
    chk("write_start_count", ws_cnt, (len > 0) ? 1 : 0);
    chk("read_count", ren_cnt, len);
    chk("beats_left", exp_beats.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
    chk("dram_start_addr", dram_xfer_start_addr, off + {48'b0, ds});
    chk("dram_size", dram_xfer_size_in_bytes, {16'b0, db});
    if (len == 0) chk("ap_done_cycle_empty", done_cyc, start_cyc + 2);
    else begin
      chk("write_start_cycle", ws_cyc, start_cyc + 1);
      chk("first_tvalid_cycle", first_tv_cyc, start_cyc + 3);
      if (wdmode == 0) chk("ap_done_after_last", done_cyc, last_cyc + 1);
      else             chk("ap_done_after_wdone", done_cyc, wd_cyc + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clear_stats();
    repeat (3) @(posedge kernel_clk);
    #1;
    chk("reset_outputs", {ap_done, write_start, save_read_buffer_r_en, save_read_buffer_r_addr,
        data_tvalid, data_tlast, |data_tdata, |dram_xfer_start_addr, |dram_xfer_size_in_bytes}, 0);
    kernel_rst = 1'b0;

    tb_seed = 32'h0;
    run(16'h0010, 16'd2, 16'h0040, 16'h0800, 64'h0, 0, 0, 0);
    run(16'h0010, 16'd2, 16'h0040, 16'h0800, 64'h0, 1, 0, 0);
    run(16'h0020, 16'd0, 16'h0010, 16'h0100, 64'h0, 0, 0, 0);
    tb_seed = $urandom();
    run(16'h1FFF, 16'd2, 16'h0000, 16'h0800, 64'h0, 0, 0, 0);
    run(16'hE005, 16'd1, 16'h0000, 16'h0400, 64'h0, 2, 1, 0);
    run(16'h0030, 16'd2, 16'h0040, 16'h0800, 64'h1000_0000, 0, 0, 1);
    run(16'h0030, 16'd2, 16'h0040, 16'h0800, 64'h1000_0000, 0, 1, 0);

    // Reset while beat 7 is on the bus.
    clear_stats();
    push_model(16'h0100, 16'd2);
    @(posedge kernel_clk); #1;
    ctrl_instruction = mkinst(16'h0100, 16'd2, 16'h0080, 16'h0800);
    ctrl_addr_offset = 64'h2000;
    ap_start = 1'b1;
    for (int b = 0; b < 200 && hs_cnt < 7; b++) begin
      @(posedge kernel_clk); #1;
      ap_start = 1'b0;
    end
    chk("beats_before_reset", hs_cnt, 7);
    kernel_rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", {ap_done, write_start, save_read_buffer_r_en, save_read_buffer_r_addr,
        data_tvalid, data_tlast, |data_tdata, |dram_xfer_start_addr, |dram_xfer_size_in_bytes}, 0);
    repeat (3) @(posedge kernel_clk);
    #1;
    chk("no_done_after_reset", done_cnt, 0);
    exp_beats.delete();
    exp_addr.delete();
    kernel_rst = 1'b0;
    run(16'h0200, 16'd1, 16'h0010, 16'h0400, 64'h3000, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      tb_seed = $urandom();
      run(16'($urandom()), 16'($urandom_range(1, 4)), 16'($urandom()), 16'($urandom()),
          {$urandom(), $urandom()}, 2, int'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
